rgb_fader: RTL
==============

RGB_FADER -- requirements
Module: rgb_fader

Interface
REQ-001 SHALL have parameter CH_W, default 8, bits per colour channel (legal 2..16).
REQ-002 SHALL have parameter STEP, default 1, per-tick channel increment/decrement (legal 1..2^CH_W-1).
REQ-003 SHALL have parameter DIV, default 1, clock cycles per ramp tick (legal >=1).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 enable  input  1  high = run; low = freeze all state.
REQ-007 colour  input  3  requested colour code: bit2 = R, bit1 = G, bit0 = B.
REQ-008 col_valid  input  1  colour request valid.
REQ-009 col_ready  output  1  request can be accepted this cycle.
REQ-010 rgb  output  3*CH_W  registered colour, {R,G,B}, R in MSBs.
REQ-011 busy  output  1  fade in progress.
REQ-012 done  output  1  one-cycle pulse when rgb reaches target.

Function
REQ-013 SHALL map each colour bit to a channel target of all-ones when set and zero when clear; code 3'b000 = black, 3'b111 = white.
REQ-014 SHALL implement states IDLE and FADE; busy SHALL be high exactly in FADE.
REQ-015 Accept = col_valid & col_ready & enable; in IDLE, col_ready SHALL equal enable.
REQ-016 On accept with target != rgb: SHALL register target, clear tick counter, go to FADE.
REQ-017 On accept with target == rgb: SHALL stay IDLE and pulse done in the next cycle; rgb unchanged.
REQ-018 In FADE, a tick SHALL occur every DIV enabled cycles; the first tick is DIV cycles after the accept edge.
REQ-019 On each tick, every channel SHALL move toward its target by STEP and saturate exactly at the target (no overshoot, no wrap); channels already at target hold.
REQ-020 The tick that makes all channels equal the target SHALL, on the same edge, set done=1 for one cycle and return to IDLE.
REQ-021 With enable low, rgb, the state, the tick counter and the target SHALL hold; col_ready=0; done=0.
REQ-022 Ramp arithmetic SHALL use CH_W+1 bits internally so that STEP near full scale cannot overflow.

Reset
REQ-023 While rst_n=0 at a clock edge: rgb=0, state=IDLE, busy=0, done=0, target=0, tick counter=0.
REQ-024 Reset mid-fade SHALL abandon the fade; the first cycle after release is IDLE with rgb=0 and col_ready=enable.

Configuration
REQ-025 Macro RGB_FADER_RETARGET_EN defined: in FADE col_ready SHALL equal enable; an accept loads the new target, clears the tick counter and continues from the current rgb; a same-colour retarget SHALL behave as REQ-017, returning to IDLE.
REQ-026 Macro undefined: col_ready SHALL be 0 in FADE; requests are held off until IDLE.

Structure
REQ-027 Shared package rgb_pkg SHALL hold the colour code constants (BLACK..WHITE, 3 bits), the state enum (IDLE, FADE) and the code-to-target function.
REQ-028 Sub-module rgb_channel_ramp (one channel: current value, target, step with saturation) SHALL be instantiated three times.

Verification (CH_W=8, STEP=64, DIV=2 unless stated)
REQ-029 Reset then colour=3'b111 accepted at edge k -> rgb ramps 0x404040, 0x808080, 0xC0C0C0, 0xFFFFFF at edges k+2, k+4, k+6, k+8; done high only in the cycle after edge k+8; busy low afterwards.
REQ-030 From white, request 3'b100 -> R holds 0xFF; G and B step 0xBF, 0x7F, 0x3F, 0x00; final rgb=0xFF0000, single done pulse.
REQ-031 In IDLE at 0x00FF00, request 3'b010 -> no state change, done pulses in the next cycle, busy stays 0.
REQ-032 Drop enable for 5 cycles mid-fade -> rgb and busy frozen, col_ready=0; ramp resumes with tick spacing intact and ends at the correct value.
REQ-033 Assert rst_n=0 for one edge mid-fade -> rgb=0, busy=0 and done=0 in the next cycle; a new request is accepted immediately.
REQ-034 Mid-fade request of 3'b000: with RGB_FADER_RETARGET_EN it is accepted and ramps down from the current value; without the macro, col_ready=0 until done, then the request is accepted.

Source files
------------

// File: rtl/rgb_pkg.sv
// rgb_pkg -- shared definitions for the RGB fader.
//   Colour codes : 3-bit {R,G,B} request codes, BLACK .. WHITE.
//   state_t      : fader control state (IDLE, FADE).
//   code_to_target() : expands a colour code into packed {R,G,B}
//                      channel targets, each all-ones or zero.
package rgb_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  localparam int MAX_CH_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  // Result is packed at ch_w bits per channel in the low 3*ch_w bits;
  // callers truncate to their own width.
  function automatic logic [3*MAX_CH_W-1:0] code_to_target(input logic [2:0] code,
                                                           input int ch_w);
    logic [3*MAX_CH_W-1:0] ones;
    logic [3*MAX_CH_W-1:0] t;
    ones = ({{(3*MAX_CH_W-1){1'b0}}, 1'b1} << ch_w) - 1'b1;
    t    = '0;
    if (code[2]) t = t | (ones << (2 * ch_w));
    if (code[1]) t = t | (ones << ch_w);
    if (code[0]) t = t | ones;
    return t;
  endfunction

endpackage

// File: rtl/rgb_channel_ramp.sv
// rgb_channel_ramp -- one colour channel of the fader.
//   Holds the channel value and, on each tick, moves it toward target by
//   STEP, landing exactly on target instead of overshooting.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (value -> 0)
//   tick       : advance one step this edge
//   target     : value the channel ramps toward
//   value      : registered channel value
//   hit_next   : the value this tick would produce equals target
module rgb_channel_ramp #(
  parameter int CH_W = 8,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [CH_W-1:0] target,
  output logic [CH_W-1:0] value,
  output logic            hit_next
);

  // One guard bit so value+STEP and target+STEP never wrap.
  localparam logic [CH_W:0] STEP_X = (CH_W+1)'(STEP);

  logic [CH_W:0]   value_x;
  logic [CH_W:0]   target_x;
  logic [CH_W:0]   up_sum;
  logic [CH_W:0]   down_lim;
  logic [CH_W-1:0] next_value;

  assign value_x  = {1'b0, value};
  assign target_x = {1'b0, target};
  assign up_sum   = value_x + STEP_X;
  assign down_lim = target_x + STEP_X;

  always_comb begin
    next_value = value;
    if (value < target) begin
      next_value = (up_sum >= target_x) ? target : up_sum[CH_W-1:0];
    end else if (value > target) begin
      // value - STEP <= target  <=>  value <= target + STEP
      next_value = (value_x <= down_lim) ? target : (value - STEP_X[CH_W-1:0]);
    end
  end

  assign hit_next = (next_value == target);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (tick) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/rgb_fader.sv
// rgb_fader -- ramps a registered {R,G,B} output toward a requested colour.
//   A colour code selects each channel as full-on or off; the output steps
//   toward it by STEP every DIV enabled cycles and pulses done on arrival.
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset
//   enable    : high = run, low = freeze all state
//   colour    : requested colour code {R,G,B}
//   col_valid : request valid
//   col_ready : request can be accepted this cycle
//   rgb       : registered colour {R,G,B}, R in MSBs
//   busy      : fade in progress
//   done      : one-cycle pulse when rgb reaches target
// Build option:
//   RGB_FADER_RETARGET_EN : accept new requests during a fade; the fade
//                           continues from the current rgb toward the new
//                           target. Undefined: requests wait for IDLE.
module rgb_fader
  import rgb_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int STEP = 1,
  parameter int DIV  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [2:0]        colour,
  input  logic              col_valid,
  output logic              col_ready,
  output logic [3*CH_W-1:0] rgb,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  state_t            state;
  state_t            state_next;
  logic [3*CH_W-1:0] target;
  logic [3*CH_W-1:0] req_target;
  logic [CNT_W-1:0]  tick_cnt;
  logic              done_r;
  logic              done_next;
  logic              accept;
  logic              same;
  logic              tick;
  logic              all_hit;
  logic [2:0]        hit;

  assign req_target = (3*CH_W)'(code_to_target(colour, CH_W));

`ifdef RGB_FADER_RETARGET_EN
  assign col_ready = enable;
`else
  assign col_ready = enable & (state == IDLE);
`endif

  assign accept  = col_valid & col_ready;
  assign same    = (req_target == rgb);
  // An accept restarts tick spacing, so it pre-empts a tick on the same edge.
  assign tick    = enable & (state == FADE) & ~accept & (tick_cnt == CNT_LAST);
  assign all_hit = &hit;
  assign busy    = (state == FADE);
  assign done    = done_r;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    rgb_channel_ramp #(
      .CH_W(CH_W),
      .STEP(STEP)
    ) u_ramp (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .target  (target[c*CH_W +: CH_W]),
      .value   (rgb[c*CH_W +: CH_W]),
      .hit_next(hit[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (accept) begin
      state_next = same ? IDLE : FADE;
      done_next  = same;
    end else if (tick && all_hit) begin
      state_next = IDLE;
      done_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target   <= '0;
      tick_cnt <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= done_next;
      if (accept) begin
        target   <= req_target;
        tick_cnt <= '0;
      end else if (enable && (state == FADE)) begin
        tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
      end
    end
  end

endmodule
